// File: rtl/column_pingpong_ctrl.sv
// Two-bank ping-pong column buffer controller: fills one bank while the
// other drains, with per-bank EMPTY/FILLING/FULL/DRAINING tracking.
module column_pingpong_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int COL_LEN    = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_start,
    output logic                  rd_busy,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic [1:0]            bank_wr_req,
    output logic [DATA_WIDTH-1:0] bank_wr_data,
    output logic [1:0]            bank_rd_req,
    output logic                  bank_rd_en,
    output logic                  bank_mode,
    output logic [1:0]            bank_full
);

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_st_e;

    localparam logic [3:0] LAST = 4'(COL_LEN - 1);

    bank_st_e bank_q [2];
    bank_st_e bank_d [2];

    logic                  wsel_q, wsel_d;
    logic                  rsel_q, rsel_d;
    logic [3:0]            wr_cnt_q, wr_cnt_d;
    logic [3:0]            rd_cnt_q, rd_cnt_d;
    logic                  drain_q, drain_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic [1:0]            wr_req_q, wr_req_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  mode_q, mode_d;

    logic wr_fire;
    logic rd_fire;
    logic all_empty;

    assign wr_ready  = (bank_q[wsel_q] == EMPTY) || (bank_q[wsel_q] == FILLING);
    assign rd_busy   = drain_q | valid_q;
    assign wr_fire   = wr_valid & wr_ready;
    assign rd_fire   = rd_start & ~rd_busy & (bank_q[rsel_q] == FULL);
    assign all_empty = (bank_q[0] == EMPTY) && (bank_q[1] == EMPTY);

    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        wsel_d    = wsel_q;
        rsel_d    = rsel_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        drain_d   = drain_q;
        wr_req_d  = 2'b00;
        wr_data_d = wr_data_q;
        mode_d    = mode_q;

        if (wr_fire) begin
            wr_req_d[wsel_q] = 1'b1;
            wr_data_d        = wr_data;
            if (wr_cnt_q == LAST) begin
                bank_d[wsel_q] = FULL;
                wr_cnt_d       = 4'd0;
                wsel_d         = ~wsel_q;
            end else begin
                bank_d[wsel_q] = FILLING;
                wr_cnt_d       = wr_cnt_q + 4'd1;
            end
        end

        // Writer and reader never touch the same bank in one cycle.
        if (rd_fire) begin
            bank_d[rsel_q] = DRAINING;
            drain_d        = 1'b1;
            rd_cnt_d       = 4'd0;
        end else if (drain_q) begin
            if (rd_cnt_q == LAST) begin
                bank_d[rsel_q] = EMPTY;
                drain_d        = 1'b0;
                rd_cnt_d       = 4'd0;
                rsel_d         = ~rsel_q;
            end else begin
                rd_cnt_d = rd_cnt_q + 4'd1;
            end
        end

        valid_d = drain_q;
        last_d  = drain_q && (rd_cnt_q == LAST);

        if (all_empty && !rd_busy) begin
            mode_d = mode;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_q[0] <= EMPTY;
            bank_q[1] <= EMPTY;
            wsel_q    <= 1'b0;
            rsel_q    <= 1'b0;
            wr_cnt_q  <= 4'd0;
            rd_cnt_q  <= 4'd0;
            drain_q   <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            wr_req_q  <= 2'b00;
            wr_data_q <= '0;
            mode_q    <= 1'b0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            wsel_q    <= wsel_d;
            rsel_q    <= rsel_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            drain_q   <= drain_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            wr_req_q  <= wr_req_d;
            wr_data_q <= wr_data_d;
            mode_q    <= mode_d;
        end
    end

    assign rd_valid     = valid_q;
    assign rd_last      = last_q;
    assign bank_wr_req  = wr_req_q;
    assign bank_wr_data = wr_data_q;
    assign bank_rd_req  = drain_q ? (rsel_q ? 2'b10 : 2'b01) : 2'b00;
    assign bank_rd_en   = drain_q;
    assign bank_mode    = mode_q;
    assign bank_full    = {bank_q[1] == FULL, bank_q[0] == FULL};

endmodule

// File: tb/tb_column_pingpong_ctrl.sv
// Directed bench for column_pingpong_ctrl: cycle table for fill/overlap/drain
// plus hand sequences for backpressure, ignored requests, mode and reset.
module tb_column_pingpong_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       rd_start;
    logic       rd_busy;
    logic       rd_valid;
    logic       rd_last;
    logic [1:0] bank_wr_req;
    logic [7:0] bank_wr_data;
    logic [1:0] bank_rd_req;
    logic       bank_rd_en;
    logic       bank_mode;
    logic [1:0] bank_full;

    column_pingpong_ctrl #(.DATA_WIDTH(8), .COL_LEN(9)) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_start(rd_start), .rd_busy(rd_busy), .rd_valid(rd_valid),
        .rd_last(rd_last), .bank_wr_req(bank_wr_req),
        .bank_wr_data(bank_wr_data), .bank_rd_req(bank_rd_req),
        .bank_rd_en(bank_rd_en), .bank_mode(bank_mode),
        .bank_full(bank_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, md, wv;
        logic [7:0] wd;
        logic       rs;
        logic       e_rdy;
        logic [1:0] e_wreq;
        logic [7:0] e_wdat;
        logic [1:0] e_rreq;
        logic       e_ren, e_busy, e_val, e_last;
        logic [1:0] e_full;
        logic       e_mode;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void add(
        logic rst, logic md, logic wv, logic [7:0] wd, logic rs,
        logic rdy, logic [1:0] wreq, logic [7:0] wdat, logic [1:0] rreq,
        logic ren, logic busy, logic val, logic last,
        logic [1:0] full, logic bm);
        vec_t v;
        v.rst = rst; v.md = md; v.wv = wv; v.wd = wd; v.rs = rs;
        v.e_rdy = rdy; v.e_wreq = wreq; v.e_wdat = wdat; v.e_rreq = rreq;
        v.e_ren = ren; v.e_busy = busy; v.e_val = val; v.e_last = last;
        v.e_full = full; v.e_mode = bm;
        tbl.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic setin(logic r, logic m, logic wv, logic [7:0] wd, logic rs);
        reset = r; mode = m; wr_valid = wv; wr_data = wd; rd_start = rs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nv;
        setin(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        // reset
        add(1,0,0,8'h00,0, 1,2'b00,8'h00,2'b00,0,0,0,0,2'b00,0);
        // fill bank 0 with 0x01..0x09
        for (int k = 1; k <= 9; k++)
            add(0,0,1,8'(k),0, 1,2'b01,8'(k),2'b00,0,0,0,0,
                (k == 9) ? 2'b01 : 2'b00, 0);
        add(0,0,0,8'h00,0, 1,2'b00,8'h00,2'b00,0,0,0,0,2'b01,0);
        // drain bank 0 while filling bank 1 with 0x10..0x18
        for (int m = 0; m <= 10; m++)
            add(0,0, m <= 8, 8'(8'h10 + m), m == 0,
                m != 8,
                (m <= 8) ? 2'b10 : 2'b00, 8'(8'h10 + m),
                (m <= 8) ? 2'b01 : 2'b00, m <= 8,
                m <= 9, (m >= 1) && (m <= 9), m == 9,
                (m >= 8) ? 2'b10 : 2'b00, 0);
        // drain bank 1
        for (int m = 0; m <= 10; m++)
            add(0,0,0,8'h00, m == 0,
                1, 2'b00, 8'h00,
                (m <= 8) ? 2'b10 : 2'b00, m <= 8,
                m <= 9, (m >= 1) && (m <= 9), m == 9,
                2'b00, 0);

        foreach (tbl[i]) begin
            setin(tbl[i].rst, tbl[i].md, tbl[i].wv, tbl[i].wd, tbl[i].rs);
            tick();
            chk($sformatf("t%0d_wr_ready", i), wr_ready, tbl[i].e_rdy);
            chk($sformatf("t%0d_wr_req", i), bank_wr_req, tbl[i].e_wreq);
            if (tbl[i].e_wreq != 2'b00)
                chk($sformatf("t%0d_wr_data", i), bank_wr_data, tbl[i].e_wdat);
            chk($sformatf("t%0d_rd_req", i), bank_rd_req, tbl[i].e_rreq);
            chk($sformatf("t%0d_rd_en", i), bank_rd_en, tbl[i].e_ren);
            chk($sformatf("t%0d_rd_busy", i), rd_busy, tbl[i].e_busy);
            chk($sformatf("t%0d_rd_valid", i), rd_valid, tbl[i].e_val);
            chk($sformatf("t%0d_rd_last", i), rd_last, tbl[i].e_last);
            chk($sformatf("t%0d_full", i), bank_full, tbl[i].e_full);
            chk($sformatf("t%0d_mode", i), bank_mode, tbl[i].e_mode);
        end

        // backpressure: 18 words fill both banks
        setin(1, 0, 0, 8'h00, 0); tick();
        for (int i = 0; i < 18; i++) begin
            setin(0, 0, 1, 8'(8'h40 + i), 0); tick();
        end
        chk("bp_ready", wr_ready, 0);
        chk("bp_full", bank_full, 2'b11);
        setin(0, 0, 1, 8'hAA, 0); tick();
        chk("bp_noaccept", bank_wr_req, 2'b00);
        setin(0, 0, 0, 8'h00, 1); tick();
        chk("bp_drain_req", bank_rd_req, 2'b01);
        chk("bp_ready_t1", wr_ready, 0);
        setin(0, 0, 0, 8'h00, 0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 8) chk("bp_ready_t9", wr_ready, 0);
            if (k == 9) chk("bp_ready_t10", wr_ready, 1);
        end
        chk("bp_full_after", bank_full, 2'b10);
        tick();
        chk("bp_idle", rd_busy, 0);

        // second request while busy is ignored
        setin(0, 0, 0, 8'h00, 1); tick();
        chk("ign_first_req", bank_rd_req, 2'b10);
        tick();
        chk("ign_busy_req", bank_rd_req, 2'b10);
        chk("ign_busy_busy", rd_busy, 1);
        chk("ign_busy_valid", rd_valid, 1);
        setin(0, 0, 0, 8'h00, 0);
        nv = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (rd_valid) nv++;
        end
        chk("ign_valid_count", nv, 8);
        chk("ign_busy_end", rd_busy, 0);
        chk("ign_full_end", bank_full, 2'b00);

        // request while empty is ignored
        setin(0, 0, 0, 8'h00, 1); tick();
        chk("empty_rd_req", bank_rd_req, 2'b00);
        chk("empty_busy", rd_busy, 0);
        setin(0, 0, 0, 8'h00, 0); tick();
        chk("empty_valid", rd_valid, 0);

        // mode loads only while both banks empty and idle
        setin(1, 0, 0, 8'h00, 0); tick();
        setin(0, 1, 0, 8'h00, 0); tick();
        chk("mode_load", bank_mode, 1);
        setin(0, 1, 1, 8'h01, 0); tick();
        setin(0, 0, 1, 8'h02, 0); tick();
        chk("mode_hold_fill", bank_mode, 1);
        for (int i = 3; i <= 9; i++) begin
            setin(0, 0, 1, 8'(i), 0); tick();
        end
        chk("mode_hold_full", bank_mode, 1);
        setin(0, 0, 0, 8'h00, 1); tick();
        setin(0, 0, 0, 8'h00, 0);
        for (int k = 0; k < 9; k++) tick();
        chk("mode_hold_t10", bank_mode, 1);
        tick();
        chk("mode_hold_t11", bank_mode, 1);
        tick();
        chk("mode_reload", bank_mode, 0);

        // reset on drain cycle 4
        setin(1, 0, 0, 8'h00, 0); tick();
        for (int i = 1; i <= 9; i++) begin
            setin(0, 0, 1, 8'(i), 0); tick();
        end
        setin(0, 0, 0, 8'h00, 1); tick();
        setin(0, 0, 0, 8'h00, 0);
        for (int k = 0; k < 3; k++) tick();
        chk("rst4_pre_req", bank_rd_req, 2'b01);
        setin(1, 0, 0, 8'h00, 0); tick();
        chk("rst4_rd_req", bank_rd_req, 2'b00);
        chk("rst4_rd_en", bank_rd_en, 0);
        chk("rst4_busy", rd_busy, 0);
        chk("rst4_valid", rd_valid, 0);
        chk("rst4_last", rd_last, 0);
        chk("rst4_wr_req", bank_wr_req, 2'b00);
        chk("rst4_full", bank_full, 2'b00);
        chk("rst4_mode", bank_mode, 0);
        chk("rst4_ready", wr_ready, 1);
        setin(0, 0, 0, 8'h00, 0); tick();
        chk("rst4_post_valid", rd_valid, 0);
        chk("rst4_post_req", bank_rd_req, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
